// File: rtl/rr_req_arbiter_pkg.sv
// Shared types and elaboration helpers for the round-robin request arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Ceiling log2, never narrower than one bit so degenerate widths stay legal.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            w = i + 1;
         end
      end
      return (w < 1) ? 1 : w;
   endfunction

   localparam int N_DEFAULT = 4;
   localparam int ID_W      = clog2(N_DEFAULT);

endpackage

// File: rtl/rr_req_arbiter_pick.sv
// Rotating-priority picker: first set request bit searching upward from last+1, wrapping at N.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] last,
   output logic            valid,
   output logic [ID_W-1:0] pick
);

   logic [2*N-1:0] dbl_req;
   logic [N-1:0]   rot_req;
   int             start_idx;
   int             enc_idx;
   logic           found;

   // Doubling the vector turns the wrap-around search into a plain right shift.
   always_comb begin
      start_idx = (int'(last) + 1) % N;
      dbl_req   = {req, req} >> start_idx;
      rot_req   = dbl_req[N-1:0];
   end

   always_comb begin
      enc_idx = 0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (rot_req[i] && !found) begin
            enc_idx = i;
            found   = 1'b1;
         end
      end
   end

   assign valid = |req;
   assign pick  = ID_W'((enc_idx + start_idx) % N);

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter with registered one-hot grant, one idle cycle between owners and a hold watchdog.
module rr_req_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N-1:0]             req,
   output logic [N-1:0]             gnt,
   output logic [clog2(N)-1:0]      gnt_id,
   output logic                     busy,
   output logic                     any_req,
   output logic                     timeout
);

   localparam int ID_W   = clog2(N);
   localparam int HOLD_W = clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LIMIT =
      (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD);
   localparam logic [ID_W-1:0] LAST_RST = ID_W'(N - 1);

   state_t            state_q, state_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
   logic              busy_q, busy_d;
   logic              any_req_q, any_req_d;
   logic              timeout_q, timeout_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [ID_W-1:0]   last_q, last_d;

   logic              pick_valid;
   logic [ID_W-1:0]   pick_idx;
   logic              owner_req;
   logic              hold_expired;

   rr_pick #(
      .N    (N),
      .ID_W (ID_W)
   ) u_pick (
      .req   (req),
      .last  (last_q),
      .valid (pick_valid),
      .pick  (pick_idx)
   );

   // Only the owner's bit is looked at while granted, so non-owner X cannot leak.
   assign owner_req    = req[gnt_id_q];
   assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_LIMIT);

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      busy_d    = busy_q;
      hold_d    = hold_q;
      last_d    = last_q;
      timeout_d = 1'b0;
      any_req_d = |req;

      case (state_q)
         GRANT: begin
            if (!owner_req || hold_expired) begin
               state_d   = GAP;
               gnt_d     = '0;
               gnt_id_d  = '0;
               busy_d    = 1'b0;
               last_d    = gnt_id_q;
               timeout_d = owner_req;
            end else if (hold_q != HOLD_LIMIT) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            if (pick_valid) begin
               state_d  = GRANT;
               gnt_d    = N'(1) << pick_idx;
               gnt_id_d = pick_idx;
               busy_d   = 1'b1;
               hold_d   = HOLD_W'(1);
            end else begin
               state_d  = IDLE;
               gnt_d    = '0;
               gnt_id_d = '0;
               busy_d   = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         busy_q    <= 1'b0;
         any_req_q <= 1'b0;
         timeout_q <= 1'b0;
         hold_q    <= '0;
         last_q    <= LAST_RST;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         busy_q    <= busy_d;
         any_req_q <= any_req_d;
         timeout_q <= timeout_d;
         hold_q    <= hold_d;
         last_q    <= last_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign busy    = busy_q;
   assign any_req = any_req_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed bench for rr_req_arbiter (N=4, MAX_HOLD=8) with a reference model feeding a scoreboard queue.
module tb_rr_req_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 8;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic [1:0]   gnt_id;
   logic         busy;
   logic         any_req;
   logic         timeout;

   int vectors;
   int miscompares;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] id;
      logic       busy;
      logic       any;
      logic       to;
      bit         chk_any;
   } exp_t;

   exp_t sb[$];

   // Reference model state: 0 idle, 1 granted, 2 gap.
   int m_state;
   int m_last;
   int m_id;
   int m_hold;

   rr_req_arbiter #(
      .N        (N),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .any_req (any_req),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         vectors++;
         assert ($onehot0(gnt)) else begin
            miscompares++;
            $error("FAIL onehot0 observed=%b required=at most one bit", gnt);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_last  = N - 1;
      m_id    = 0;
      m_hold  = 0;
   endtask

   task automatic step(input logic [3:0] r, input bit chk_any);
      exp_t e;
      bit   found;
      int   idx;
      e.to      = 1'b0;
      e.chk_any = chk_any;
      e.any     = |r;
      if (m_state == 1) begin
         if (r[m_id] !== 1'b1) begin
            m_last  = m_id;
            m_state = 2;
         end else if (m_hold == MAX_HOLD) begin
            m_last  = m_id;
            m_state = 2;
            e.to    = 1'b1;
         end else begin
            m_hold++;
         end
      end else begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (!found && r[idx] === 1'b1) begin
               found = 1'b1;
               m_id  = idx;
            end
         end
         if (found) begin
            m_state = 1;
            m_hold  = 1;
         end else begin
            m_state = 0;
         end
      end
      e.gnt  = (m_state == 1) ? 4'(1 << m_id) : 4'b0000;
      e.id   = (m_state == 1) ? 2'(m_id) : 2'd0;
      e.busy = (m_state == 1);
      sb.push_back(e);

      req = r;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      $display("step req=%b gnt=%b id=%0d busy=%b any=%b to=%b", r, gnt, gnt_id, busy, any_req, timeout);
      check("gnt", 32'(gnt), 32'(e.gnt));
      check("gnt_id", 32'(gnt_id), 32'(e.id));
      check("busy", 32'(busy), 32'(e.busy));
      check("timeout", 32'(timeout), 32'(e.to));
      if (e.chk_any) check("any_req", 32'(any_req), 32'(e.any));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      @(posedge clk);
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_gnt_id", 32'(gnt_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_any_req", 32'(any_req), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int order[$];
      int exp_order[5];
      int gap_len;
      logic prev_busy;
      logic [3:0] r;
      int run_len;
      bit to_seen;
      bit rot_checked;
      int g3_count;

      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      req         = '0;
      model_reset();
      @(posedge clk);
      do_reset();

      // Single requester, grant and release.
      step(4'b0001, 1'b1);
      check("a_first_gnt", 32'(gnt), 32'h1);
      step(4'b0001, 1'b1);
      step(4'b0000, 1'b1);
      check("a_release", 32'(gnt), 32'h0);
      step(4'b0000, 1'b1);

      // All requesting; each owner drops after two granted cycles.
      do_reset();
      exp_order = '{0, 1, 2, 3, 0};
      prev_busy = 1'b0;
      gap_len   = 0;
      for (int i = 0; i < 14; i++) begin
         r = 4'b1111;
         if (m_state == 1 && m_hold == 2) r[m_id] = 1'b0;
         step(r, 1'b1);
         if (busy && !prev_busy) begin
            if (order.size() > 0) check("b_gap_len", 32'(gap_len), 32'd1);
            order.push_back(int'(gnt_id));
            gap_len = 0;
         end else if (!busy) begin
            gap_len++;
         end
         prev_busy = busy;
      end
      check("b_grant_count", 32'(order.size()), 32'd5);
      for (int i = 0; i < 5 && i < order.size(); i++) begin
         check("b_grant_order", 32'(order[i]), 32'(exp_order[i]));
      end
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);

      // Sole requester hogs the resource: watchdog revokes, then regrants.
      do_reset();
      run_len = 0;
      to_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(4'b0100, 1'b1);
         if (timeout) begin
            to_seen = 1'b1;
            check("c_gnt_at_timeout", 32'(gnt), 32'h0);
         end else if (!to_seen && gnt == 4'b0100) begin
            run_len++;
         end
      end
      check("c_hold_cycles", 32'(run_len), 32'd8);
      check("c_timeout_seen", 32'(to_seen), 32'd1);
      check("c_regrant", 32'(gnt), 32'h4);

      // Owner 2 times out with requester 0 waiting: rotation moves to 0.
      to_seen     = 1'b0;
      rot_checked = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(4'b0101, 1'b1);
         if (to_seen && !rot_checked) begin
            check("d_rotate_after_timeout", 32'(gnt), 32'h1);
            rot_checked = 1'b1;
         end
         if (timeout) to_seen = 1'b1;
      end
      check("d_rotation_checked", 32'(rot_checked), 32'd1);
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);

      // Asynchronous reset in mid-grant.
      do_reset();
      step(4'b1000, 1'b1);
      step(4'b1000, 1'b1);
      check("e_pre_reset_gnt", 32'(gnt), 32'h8);
      #2;
      rst_n = 1'b0;
      #1;
      check("e_async_gnt", 32'(gnt), 32'h0);
      check("e_async_busy", 32'(busy), 32'd0);
      model_reset();
      #1;
      rst_n = 1'b1;
      step(4'b1001, 1'b1);
      check("e_first_after_reset", 32'(gnt), 32'h1);
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);

      // Non-owner pulse and X on non-owner bits while owner 1 holds.
      do_reset();
      g3_count = 0;
      step(4'b0010, 1'b1);
      step(4'b1010, 1'b1);
      if (gnt[3]) g3_count++;
      step(4'b0010, 1'b1);
      if (gnt[3]) g3_count++;
      step(4'bxx1x, 1'b0);
      if (gnt[3]) g3_count++;
      step(4'b0010, 1'b1);
      if (gnt[3]) g3_count++;
      step(4'b0000, 1'b1);
      if (gnt[3]) g3_count++;
      step(4'b0000, 1'b1);
      if (gnt[3]) g3_count++;
      check("f_no_grant_to_3", 32'(g3_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "time limit");
   end

endmodule
